// File: rtl/uart_pkg.sv
// Shared constants for the Wishbone UART transmitter: register map, status bits, FSM encoding.
// Also holds the bit-time reload helper used by the serialiser.
package uart_pkg;

  localparam logic REG_DATA = 1'b0;
  localparam logic REG_DIV  = 1'b1;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_LVL_LSB = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_t;

  // A stored divisor of 0 behaves as 1, so the reload is max(div,1)-1.
  function automatic logic [15:0] bit_reload(input logic [15:0] div);
    return (div == 16'd0) ? 16'd0 : div - 16'd1;
  endfunction

endpackage

// File: rtl/wb_uart_tx_if.sv
// Wishbone slave signal bundle for the UART transmitter (decoder-qualified cycle, single-cycle ack).
interface wb_uart_tx_if;
  logic        wb_cyc;
  logic        wb_we;
  logic        wb_adr;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack;

  modport master (
    output wb_cyc, wb_we, wb_adr, wb_dat_i,
    input  wb_dat_o, wb_ack
  );

  modport slave (
    input  wb_cyc, wb_we, wb_adr, wb_dat_i,
    output wb_dat_o, wb_ack
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read; push and pop may share an edge.
// A push while full is accepted only when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/wb_uart_tx.sv
// Wishbone-attached 8N1 UART transmitter: byte FIFO, run-time baud divisor, status register.
// One-cycle ack per cycle; bytes written while the FIFO is full are dropped and flagged.
module wb_uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 104,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        wb_ck,
  input  logic        wb_rst,
  wb_uart_tx_if.slave wb,
  output logic        tx,
  output logic        tx_empty
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          done;
  logic          ack_q;
  logic [31:0]   dat_q;
  logic          overflow;
  logic [15:0]   divisor;

  logic          access;
  logic          wr_data;
  logic          wr_div;
  logic          rd_status;
  logic [31:0]   status;
  logic [31:0]   rd_mux;
  logic          unused_dat;

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_dout;
  logic [LW-1:0] fifo_level;

  tx_state_t     state;
  tx_state_t     state_d;
  logic [7:0]    shift;
  logic [7:0]    shift_d;
  logic [2:0]    bit_cnt;
  logic [2:0]    bit_cnt_d;
  logic [15:0]   baud_cnt;
  logic [15:0]   baud_d;
  logic          tx_d;
  logic          bit_end;

  assign unused_dat = ^wb.wb_dat_i[31:16];

  // Bus access

  assign access    = wb.wb_cyc && !done;
  assign wr_data   = access &&  wb.wb_we && (wb.wb_adr == REG_DATA);
  assign wr_div    = access &&  wb.wb_we && (wb.wb_adr == REG_DIV);
  assign rd_status = access && !wb.wb_we && (wb.wb_adr == REG_DATA);

  assign fifo_push = wr_data && (!fifo_full || fifo_pop);

  always_comb begin
    status               = '0;
    status[ST_EMPTY]     = fifo_empty;
    status[ST_FULL]      = fifo_full;
    status[ST_BUSY]      = (state != S_IDLE);
    status[ST_OVF]       = overflow;
    status[ST_LVL_LSB +: 8] = 8'(fifo_level);
  end

  assign rd_mux = (wb.wb_adr == REG_DIV) ? {16'b0, divisor} : status;

  always_ff @(posedge wb_ck or posedge wb_rst) begin
    if (wb_rst) begin
      done     <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      overflow <= 1'b0;
      divisor  <= 16'(CLK_DIV);
    end else begin
      ack_q <= access;
      dat_q <= (access && !wb.wb_we) ? rd_mux : '0;
      done  <= wb.wb_cyc ? (done || access) : 1'b0;
      if (wr_div) divisor <= wb.wb_dat_i[15:0];
      if (wr_data && fifo_full && !fifo_pop) overflow <= 1'b1;
      else if (rd_status)                    overflow <= 1'b0;
    end
  end

  assign wb.wb_ack   = ack_q;
  assign wb.wb_dat_o = dat_q;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (wb_ck),
    .rst   (wb_rst),
    .push  (fifo_push),
    .din   (wb.wb_dat_i[7:0]),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Serialiser: divisor is only sampled at bit starts, so a mid-frame change
  // never alters the bit currently on the line.

  assign bit_end = (baud_cnt == 16'd0);

  always_comb begin
    state_d   = state;
    shift_d   = shift;
    bit_cnt_d = bit_cnt;
    baud_d    = bit_end ? baud_cnt : baud_cnt - 16'd1;
    tx_d      = tx;
    fifo_pop  = 1'b0;

    case (state)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shift_d   = fifo_dout;
          bit_cnt_d = 3'd0;
          baud_d    = bit_reload(divisor);
          state_d   = S_START;
          tx_d      = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          baud_d  = bit_reload(divisor);
          tx_d    = shift[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d = bit_reload(divisor);
          if (bit_cnt == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d   = {1'b0, shift[7:1]};
            bit_cnt_d = bit_cnt + 3'd1;
            tx_d      = shift[1];
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            shift_d   = fifo_dout;
            bit_cnt_d = 3'd0;
            baud_d    = bit_reload(divisor);
            state_d   = S_START;
            tx_d      = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge wb_ck or posedge wb_rst) begin
    if (wb_rst) begin
      state    <= S_IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      tx       <= 1'b1;
      tx_empty <= 1'b1;
    end else begin
      state    <= state_d;
      shift    <= shift_d;
      bit_cnt  <= bit_cnt_d;
      baud_cnt <= baud_d;
      tx       <= tx_d;
      tx_empty <= fifo_empty && (state == S_IDLE);
    end
  end

endmodule

// File: tb/tb_wb_uart_tx.sv
// Directed bench for wb_uart_tx: bus handshake, frame timing, FIFO overflow, divisor, async reset.
module tb_wb_uart_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx;
  logic tx_empty;
  int   checks   = 0;
  int   failures = 0;
  int   ncyc     = 0;
  int   base     = 0;
  logic [31:0] rdat;
  logic [9:0]  f55 = {1'b1, 8'h55, 1'b0};
  logic [9:0]  f81 = {1'b1, 8'h81, 1'b0};
  logic [19:0] fab = {1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0};

  wb_uart_tx_if bus();

  wb_uart_tx #(
    .CLK_DIV    (104),
    .FIFO_DEPTH (4)
  ) dut (
    .wb_ck    (clk),
    .wb_rst   (rst),
    .wb       (bus),
    .tx       (tx),
    .tx_empty (tx_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    ncyc++;
  endtask

  task automatic wait_to(input int t);
    while (ncyc < t) tick();
  endtask

  task automatic bus_xfer(input logic we, input logic adr, input logic [31:0] wdat,
                          output logic [31:0] data);
    logic got;
    got = 1'b0;
    bus.wb_cyc   = 1'b1;
    bus.wb_we    = we;
    bus.wb_adr   = adr;
    bus.wb_dat_i = wdat;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      got = bus.wb_ack;
    end
    check("bus_ack", 32'(got), 32'd1);
    data         = bus.wb_dat_o;
    bus.wb_cyc   = 1'b0;
    bus.wb_we    = 1'b0;
    tick();
  endtask

  task automatic wr(input logic adr, input logic [31:0] wdat);
    logic [31:0] dummy;
    bus_xfer(1'b1, adr, wdat, dummy);
  endtask

  task automatic rd(input logic adr, output logic [31:0] data);
    bus_xfer(1'b0, adr, 32'd0, data);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wb_cyc   = 1'b0;
    bus.wb_we    = 1'b0;
    bus.wb_adr   = 1'b0;
    bus.wb_dat_i = '0;

    // Reset state
    repeat (3) tick();
    check("rst_tx",       32'(tx),         32'd1);
    check("rst_tx_empty", 32'(tx_empty),   32'd1);
    check("rst_ack",      32'(bus.wb_ack), 32'd0);
    check("rst_dat_o",    bus.wb_dat_o,    32'd0);
    rst = 1'b0;
    repeat (20) tick();
    check("idle_tx",       32'(tx),         32'd1);
    check("idle_tx_empty", 32'(tx_empty),   32'd1);
    check("idle_ack",      32'(bus.wb_ack), 32'd0);
    rd(1'b1, rdat);
    check("div_reset", rdat, 32'd104);

    // Held cycle: single ack, then a 0x55 frame at 104 clocks per bit
    base = ncyc;
    bus.wb_cyc   = 1'b1;
    bus.wb_we    = 1'b1;
    bus.wb_adr   = 1'b0;
    bus.wb_dat_i = 32'h0000_0055;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("hold_ack_c%0d", k), 32'(bus.wb_ack), (k == 1) ? 32'd1 : 32'd0);
    end
    bus.wb_cyc = 1'b0;
    bus.wb_we  = 1'b0;
    for (int j = 0; j < 10; j++) begin
      if (j > 0) begin
        wait_to(base + 2 + 104 * j);
        check($sformatf("f55_first_b%0d", j), 32'(tx), 32'(f55[j]));
      end
      wait_to(base + 2 + 104 * j + 103);
      check($sformatf("f55_last_b%0d", j), 32'(tx), 32'(f55[j]));
    end
    wait_to(base + 1042);
    check("f55_empty_stop", 32'(tx_empty), 32'd0);
    tick();
    check("f55_empty_rise", 32'(tx_empty), 32'd1);

    // Overflow: divisor 4, six writes while the first frame is in flight
    wr(1'b1, 32'd4);
    rd(1'b1, rdat);
    check("div_4", rdat, 32'd4);
    for (int b = 0; b < 6; b++) wr(1'b0, 32'h11 + 32'(b));
    rd(1'b0, rdat);
    check("ovf_status1", rdat, 32'h0000_040E);
    rd(1'b0, rdat);
    check("ovf_status2", rdat, 32'h0000_0406);
    for (int i = 0; i < 600 && !tx_empty; i++) tick();
    check("ovf_drain", 32'(tx_empty), 32'd1);
    rd(1'b0, rdat);
    check("drained_status", rdat, 32'h0000_0001);

    // Back-to-back frames 0xA5, 0x3C with no idle gap
    base = ncyc;
    wr(1'b0, 32'hA5);
    wr(1'b0, 32'h3C);
    for (int j = 0; j < 20; j++) begin
      if (j > 0) begin
        wait_to(base + 2 + 4 * j);
        check($sformatf("b2b_first_b%0d", j), 32'(tx), 32'(fab[j]));
      end
      wait_to(base + 5 + 4 * j);
      check($sformatf("b2b_last_b%0d", j), 32'(tx), 32'(fab[j]));
    end
    wait_to(base + 82);
    check("b2b_empty_stop", 32'(tx_empty), 32'd0);
    tick();
    check("b2b_empty_rise", 32'(tx_empty), 32'd1);

    // Divisor 0 behaves as 1: one clock per bit
    wr(1'b1, 32'd0);
    rd(1'b1, rdat);
    check("div_0", rdat, 32'd0);
    base = ncyc;
    wr(1'b0, 32'h81);
    for (int j = 0; j < 10; j++) begin
      wait_to(base + 2 + j);
      check($sformatf("f81_b%0d", j), 32'(tx), 32'(f81[j]));
    end
    wait_to(base + 12);
    check("f81_empty_stop", 32'(tx_empty), 32'd0);
    tick();
    check("f81_empty_rise", 32'(tx_empty), 32'd1);

    // Asynchronous reset in the middle of a DATA bit
    wr(1'b1, 32'd8);
    base = ncyc;
    wr(1'b0, 32'hF0);
    wr(1'b0, 32'h11);
    wr(1'b0, 32'h22);
    rd(1'b0, rdat);
    check("pre_rst_status", rdat, 32'h0000_0204);
    wait_to(base + 20);
    check("pre_rst_tx", 32'(tx), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_tx",       32'(tx),         32'd1);
    check("async_rst_tx_empty", 32'(tx_empty),   32'd1);
    check("async_rst_ack",      32'(bus.wb_ack), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    rd(1'b0, rdat);
    check("post_rst_status", rdat, 32'h0000_0001);
    rd(1'b1, rdat);
    check("post_rst_div", rdat, 32'd104);
    check("post_rst_tx", 32'(tx), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
